// File: rtl/id_stage.sv
// Registered MIPS decode stage: combinational decode of IF/ID, ID/EX register,
// load-use stall, branch/jump flush and issue hold while a multi-cycle mul owns EX.
module id_stage #(
  parameter int MUL_CYCLES = 3,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  output logic        id_valid,
  output logic [15:0] id_ctrl,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [31:0] id_pc4,
  output logic        dbg_state,
  output logic [3:0]  dbg_cnt
);

  // Handshake: fetch advances PC and IF/ID on any cycle where id_ready is 1;
  // if_valid only qualifies whether the consumed contents are a real instruction.

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_INIT  = 4'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       load;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic is_r, is_jr, is_shift, is_mul, is_j, is_jal, is_beq, is_lw, is_sw, is_lui;
  logic ext_op, reads_rt, hazard;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic [15:0] ctrl;
  logic [31:0] imm_ext;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign funct = if_instr[5:0];
  assign imm16 = if_instr[15:0];

  assign is_r     = (op == OP_R);
  assign is_jr    = is_r && (funct == 6'h08);
  assign is_shift = is_r && ((funct == 6'h00) || (funct == 6'h02) || (funct == 6'h03));
  assign is_mul   = (op == OP_MUL) && (funct == 6'h02);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_lui   = (op == OP_LUI);

  always_comb begin
    pc_src = 2'b00;
    if (is_j || is_jal) pc_src = 2'b01;
    else if (is_jr)     pc_src = 2'b10;

    reg_dst = 2'b00;
    if (is_jr || is_sw || is_beq || is_j || is_jal) reg_dst = 2'b10;
    else if (is_r || is_mul)                        reg_dst = 2'b01;

    mem_to_reg = 2'b00;
    if (is_lw)       mem_to_reg = 2'b01;
    else if (is_jal) mem_to_reg = 2'b10;

    alu_op = 3'b000;
    if (is_r)                                alu_op = 3'b010;
    else if (is_beq)                         alu_op = 3'b001;
    else if (op == OP_ANDI)                  alu_op = 3'b100;
    else if (op == OP_SLTI || op == OP_SLTIU) alu_op = 3'b101;
    else if (is_mul)                         alu_op = 3'b110;

    ext_op = !is_lui;
    if (ZEXT_LOGIC && (op == OP_ANDI || op == OP_ORI || op == OP_XORI)) ext_op = 1'b0;

    imm_ext = ext_op ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
    if (is_lui) imm_ext = {imm16, 16'h0000};
  end

  assign ctrl = {pc_src, is_beq, !(is_sw || is_beq || is_j || is_jr), reg_dst,
                 is_lw, is_sw, mem_to_reg, is_shift, !(is_r || is_mul || is_beq),
                 op[0], alu_op};

  // Only instructions that actually source rt may stall on a match against it.
  assign reads_rt = is_r || is_mul || is_beq || is_sw;
  assign hazard   = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && reads_rt));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    id_ready = 1'b1;
    load     = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          id_ready = 1'b1;
        end else if (if_valid && hazard) begin
          id_ready = 1'b0;
        end else if (if_valid) begin
          load = 1'b1;
          if (is_mul && MUL_MULTI) begin
            state_n = MUL_WAIT;
            cnt_n   = MUL_INIT;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_n = RUN;
          cnt_n   = 4'd0;
        end else begin
          id_ready = 1'b0;
          cnt_n    = cnt - 4'd1;
          if (cnt == 4'd1) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 4'd0;
      id_valid <= 1'b0;
      id_ctrl  <= 16'h0000;
      id_imm   <= 32'h0;
      id_rs    <= 5'd0;
      id_rt    <= 5'd0;
      id_rd    <= 5'd0;
      id_shamt <= 5'd0;
      id_pc4   <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        id_valid <= 1'b1;
        id_ctrl  <= ctrl;
        id_imm   <= imm_ext;
        id_rs    <= rs;
        id_rt    <= rt;
        id_rd    <= if_instr[15:11];
        id_shamt <= if_instr[10:6];
        id_pc4   <= if_pc4;
      end else begin
        // Bubble: kill the controls, leave the datapath fields as they were.
        id_valid <= 1'b0;
        id_ctrl  <= 16'h0000;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule
